// File: rtl/mp_addsub_seq_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package mp_addsub_seq_pkg;

    localparam int WORD_SIZE = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic logic word_is_zero(input logic [WORD_SIZE-1:0] w);
        return (w == {WORD_SIZE{1'b0}});
    endfunction

endpackage

// File: rtl/mp_addsub_seq_addsub.sv
// Single W-bit adder/subtractor; carry_i gates cin_i, sub_i inverts b and forces carry-in.
module mp_addsub_seq_addsub
    import mp_addsub_seq_pkg::*;
#(
    parameter int W = WORD_SIZE
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    input  logic         carry_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W-1:0] b_s;
    logic         c_s;
    logic [W:0]   full_s;

    // Operand conditioning and the W+1 bit add.
    always_comb begin
        if (sub_i) begin
            b_s = ~b_i;
            c_s = 1'b1;
        end else begin
            b_s = b_i;
            c_s = carry_i & cin_i;
        end
        full_s = {1'b0, a_i} + {1'b0, b_s} + {{W{1'b0}}, c_s};
    end

    assign sum_o  = full_s[W-1:0];
    assign cout_o = full_s[W];

endmodule

// File: rtl/mp_addsub_seq.sv
// Multi-precision add/subtract sequencer: streams LSW-first operand words through one
// adder, chaining the carry, and writes one result word per cycle.
module mp_addsub_seq
    import mp_addsub_seq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op_sub,
    input  logic [LEN_W-1:0]     len,
    input  logic [ADDR_W-1:0]    x_base,
    input  logic [ADDR_W-1:0]    y_base,
    input  logic [ADDR_W-1:0]    d_base,
    output logic                 busy,
    output logic                 done,
    output logic                 cout,
    output logic                 zero,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    x_raddr,
    output logic [ADDR_W-1:0]    y_raddr,
    input  logic [WORD_SIZE-1:0] x_rdata,
    input  logic [WORD_SIZE-1:0] y_rdata,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    waddr,
    output logic [WORD_SIZE-1:0] wdata
);

    localparam logic [ADDR_W-1:0]    ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0]    ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]     LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]     LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [WORD_SIZE-1:0] WORD_ZERO = {WORD_SIZE{1'b0}};

    state_e                state_q, state_d;
    logic                  op_sub_q, op_sub_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic [ADDR_W-1:0]     x_raddr_q, x_raddr_d;
    logic [ADDR_W-1:0]     y_raddr_q, y_raddr_d;
    logic [ADDR_W-1:0]     dptr_q, dptr_d;
    logic [ADDR_W-1:0]     waddr_q, waddr_d;
    logic                  rd_en_q, rd_en_d;
    logic                  wr_en_q, wr_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  carry_q, carry_d;
    logic                  cout_q, cout_d;
    logic                  zero_q, zero_d;

    logic                  start_acc_s;
    logic [WORD_SIZE-1:0]  y_eff_s;
    logic [WORD_SIZE-1:0]  sum_s;
    logic                  sum_cout_s;

    assign start_acc_s = (state_q == S_IDLE) & start;

    // Subtraction is X + ~Y + carry; the adder's own sub mode would pin carry-in
    // to 1 on every word and break borrow chaining, so inversion happens here.
    always_comb begin
        case (op_sub_q)
            OP_SUB:  y_eff_s = ~y_rdata;
            OP_ADD:  y_eff_s = y_rdata;
            default: y_eff_s = y_rdata;
        endcase
    end

    mp_addsub_seq_addsub #(
        .W (WORD_SIZE)
    ) u_addsub (
        .a_i     (x_rdata),
        .b_i     (y_eff_s),
        .sub_i   (1'b0),
        .carry_i (1'b1),
        .cin_i   (carry_q),
        .sum_o   (sum_s),
        .cout_o  (sum_cout_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (len != LEN_ZERO) ? S_RUN : S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (rem_q == LEN_ZERO) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs, derived from the next state so the strobes come out registered.
    always_comb begin
        busy_d  = (state_d == S_RUN) | (state_d == S_DRAIN);
        done_d  = (state_d == S_DONE);
        rd_en_d = (state_d == S_RUN);
    end

    // Datapath next-state: field latching, address walk, carry chain and flags.
    always_comb begin
        op_sub_d  = op_sub_q;
        rem_d     = rem_q;
        x_raddr_d = x_raddr_q;
        y_raddr_d = y_raddr_q;
        dptr_d    = dptr_q;
        waddr_d   = waddr_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        wr_en_d   = rd_en_q;
        if (start_acc_s) begin
            op_sub_d  = op_sub;
            rem_d     = len - LEN_ONE;
            x_raddr_d = x_base;
            y_raddr_d = y_base;
            dptr_d    = d_base;
            // Seeding the chain with op_sub makes word 0 see cin = op_sub.
            carry_d   = op_sub;
            zero_d    = 1'b1;
        end else begin
            if ((state_q == S_RUN) && (rem_q != LEN_ZERO)) begin
                rem_d     = rem_q - LEN_ONE;
                x_raddr_d = x_raddr_q + ADDR_ONE;
                y_raddr_d = y_raddr_q + ADDR_ONE;
            end else begin
                rem_d = rem_q;
            end
            if (rd_en_q) begin
                waddr_d = dptr_q;
                dptr_d  = dptr_q + ADDR_ONE;
            end else begin
                dptr_d = dptr_q;
            end
            if (wr_en_q) begin
                carry_d = sum_cout_s;
                zero_d  = zero_q & word_is_zero(sum_s);
            end else begin
                carry_d = carry_q;
            end
        end
        cout_d = (state_d == S_DONE) ? carry_d : cout_q;
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_sub_q  <= 1'b0;
            rem_q     <= LEN_ZERO;
            x_raddr_q <= ADDR_ZERO;
            y_raddr_q <= ADDR_ZERO;
            dptr_q    <= ADDR_ZERO;
            waddr_q   <= ADDR_ZERO;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            zero_q    <= 1'b1;
        end else begin
            op_sub_q  <= op_sub_d;
            rem_q     <= rem_d;
            x_raddr_q <= x_raddr_d;
            y_raddr_q <= y_raddr_d;
            dptr_q    <= dptr_d;
            waddr_q   <= waddr_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            zero_q    <= zero_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign cout    = cout_q;
    assign zero    = zero_q;
    assign rd_en   = rd_en_q;
    assign x_raddr = x_raddr_q;
    assign y_raddr = y_raddr_q;
    assign wr_en   = wr_en_q;
    assign waddr   = waddr_q;
    // Read data only arrives in the write cycle, so the result word comes straight off the adder.
    assign wdata   = wr_en_q ? sum_s : WORD_ZERO;

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Randomised bench for mp_addsub_seq: a whole-vector arithmetic model predicts every
// cycle's outputs; directed operations pin the model to hand-computed values.
module tb_mp_addsub_seq;

    logic       clk = 1'b0;
    logic       rst, start, op_sub;
    logic [7:0] len, x_base, y_base, d_base;
    logic       busy, done, cout, zero, rd_en, wr_en;
    logic [7:0] x_raddr, y_raddr, waddr, wdata;
    logic [7:0] x_rdata = 8'h00;
    logic [7:0] y_rdata = 8'h00;

    logic [7:0] xmem [0:255];
    logic [7:0] ymem [0:255];
    logic [7:0] dmem [0:255];

    int checks = 0;
    int errors = 0;

    mp_addsub_seq #(.ADDR_W(8), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .len(len),
        .x_base(x_base), .y_base(y_base), .d_base(d_base),
        .busy(busy), .done(done), .cout(cout), .zero(zero),
        .rd_en(rd_en), .x_raddr(x_raddr), .y_raddr(y_raddr),
        .x_rdata(x_rdata), .y_rdata(y_rdata),
        .wr_en(wr_en), .waddr(waddr), .wdata(wdata)
    );

    always #5 clk = ~clk;

    // Operand store with one-cycle read latency, and the result store.
    always @(posedge clk) begin
        if (rd_en) begin
            x_rdata <= xmem[x_raddr];
            y_rdata <= ymem[y_raddr];
        end
        if (wr_en) dmem[waddr] <= wdata;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    int   cyc = 0;
    bit   mv = 1'b0;
    bit   act = 1'b0;
    int   c0, mn, dcyc, mxb, myb, mdb;
    logic [7:0] expd [0:15];
    logic ecout, ezero;
    logic hcout = 1'b0;
    logic hzero = 1'b1;

    // One compare process: every cycle, outputs against the model's prediction.
    always @(negedge clk) begin : cmp
        int k;
        bit eb, erd, ewr;
        logic [128:0] vx, vy, vd, msk;
        cyc++;
        if (mv) begin
            if (act && cyc > c0 && cyc <= dcyc) begin
                k   = cyc - c0;
                eb  = (mn != 0) && k >= 1 && k <= mn + 1;
                erd = (mn != 0) && k >= 1 && k <= mn;
                ewr = (mn != 0) && k >= 2 && k <= mn + 1;
                chk("busy", busy, eb);
                chk("done", done, cyc == dcyc);
                chk("rd_en", rd_en, erd);
                chk("wr_en", wr_en, ewr);
                if (erd) begin
                    chk("x_raddr", x_raddr, (mxb + k - 1) & 255);
                    chk("y_raddr", y_raddr, (myb + k - 1) & 255);
                end
                if (ewr) begin
                    chk("waddr", waddr, (mdb + k - 2) & 255);
                    chk("wdata", wdata, expd[k-2]);
                end
                if (cyc == dcyc) begin
                    chk("cout_done", cout, ecout);
                    chk("zero_done", zero, ezero);
                    hcout = ecout;
                    hzero = ezero;
                end
            end else begin
                chk("busy_idle", busy, 1'b0);
                chk("done_idle", done, 1'b0);
                chk("rd_en_idle", rd_en, 1'b0);
                chk("wr_en_idle", wr_en, 1'b0);
                chk("cout_hold", cout, hcout);
                chk("zero_hold", zero, hzero);
            end
        end
        if (rst) begin
            mv = 1'b1;
            act = 1'b0;
            hcout = 1'b0;
            hzero = 1'b1;
        end else if (mv && start && (!act || cyc > dcyc)) begin
            act = 1'b1;
            c0 = cyc;
            mn = int'(len);
            mxb = int'(x_base);
            myb = int'(y_base);
            mdb = int'(d_base);
            vx = '0;
            vy = '0;
            for (int i = 0; i < mn; i++) begin
                vx[8*i +: 8] = xmem[(mxb + i) & 255];
                vy[8*i +: 8] = ymem[(myb + i) & 255];
            end
            msk = (129'd1 << (8 * mn)) - 129'd1;
            if (op_sub) begin
                ecout = (vx >= vy);
                vd = (vx - vy) & msk;
            end else begin
                vd = vx + vy;
                ecout = vd[8*mn];
                vd = vd & msk;
            end
            ezero = (vd == 129'd0);
            for (int i = 0; i < 16; i++) expd[i] = vd[8*i +: 8];
            dcyc = (mn == 0) ? c0 + 1 : c0 + mn + 2;
        end
    end

    // One operation from the idle state; optional ignored start pulse in cycle 2.
    task automatic do_op(input logic sub, input int n, input int xb, input int yb, input int db,
                         input bit mid, output int done_at, output int wr_seen,
                         output logic dc, output logic dz);
        @(posedge clk); #1;
        start = 1'b1; op_sub = sub; len = 8'(n);
        x_base = 8'(xb); y_base = 8'(yb); d_base = 8'(db);
        done_at = -1; wr_seen = 0; dc = 1'bx; dz = 1'bx;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            start = mid && (k == 2);
            if (mid && k == 2) begin
                op_sub = ~sub; len = 8'd5; x_base = 8'h80; y_base = 8'h90; d_base = 8'hA0;
            end
            @(negedge clk);
            if (wr_en) wr_seen++;
            if (done) begin
                done_at = k; dc = cout; dz = zero;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin : stim
        int dat, ws;
        logic dc, dz;
        rst = 1'b1; start = 1'b0; op_sub = 1'b0; len = 8'd0;
        x_base = 8'd0; y_base = 8'd0; d_base = 8'd0;
        for (int i = 0; i < 256; i++) begin
            xmem[i] = 8'($urandom);
            ymem[i] = xmem[i];
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_zero", zero, 1'b1);
        chk("rst_x_raddr", x_raddr, 8'h00);
        chk("rst_y_raddr", y_raddr, 8'h00);
        chk("rst_waddr", waddr, 8'h00);
        chk("rst_wdata", wdata, 8'h00);

        // add, n=2
        xmem[8'h10] = 8'h01; xmem[8'h11] = 8'hFF; ymem[8'h20] = 8'h00; ymem[8'h21] = 8'h01;
        do_op(1'b0, 2, 8'h10, 8'h20, 8'h30, 1'b0, dat, ws, dc, dz);
        chk("add2_done_at", dat, 4);
        chk("add2_writes", ws, 2);
        chk("add2_d0", dmem[8'h30], 8'h01);
        chk("add2_d1", dmem[8'h31], 8'h00);
        chk("add2_cout", dc, 1'b1);
        chk("add2_zero", dz, 1'b0);

        // sub, n=3, borrow ripples through two words
        xmem[8'h12] = 8'h00; xmem[8'h13] = 8'h00; xmem[8'h14] = 8'h01;
        ymem[8'h24] = 8'h01; ymem[8'h25] = 8'h00; ymem[8'h26] = 8'h00;
        do_op(1'b1, 3, 8'h12, 8'h24, 8'h34, 1'b0, dat, ws, dc, dz);
        chk("sub3_done_at", dat, 5);
        chk("sub3_d0", dmem[8'h34], 8'hFF);
        chk("sub3_d1", dmem[8'h35], 8'hFF);
        chk("sub3_d2", dmem[8'h36], 8'h00);
        chk("sub3_cout", dc, 1'b1);

        // sub, n=1, equal operands
        xmem[8'h18] = 8'h05; ymem[8'h28] = 8'h05;
        do_op(1'b1, 1, 8'h18, 8'h28, 8'h38, 1'b0, dat, ws, dc, dz);
        chk("sub_eq_d0", dmem[8'h38], 8'h00);
        chk("sub_eq_zero", dz, 1'b1);
        chk("sub_eq_cout", dc, 1'b1);

        // sub, n=1, borrow out
        xmem[8'h19] = 8'h03; ymem[8'h29] = 8'h05;
        do_op(1'b1, 1, 8'h19, 8'h29, 8'h39, 1'b0, dat, ws, dc, dz);
        chk("sub_bw_d0", dmem[8'h39], 8'hFE);
        chk("sub_bw_cout", dc, 1'b0);
        chk("sub_bw_zero", dz, 1'b0);

        // len=0, add and sub
        do_op(1'b0, 0, 8'h00, 8'h00, 8'h00, 1'b0, dat, ws, dc, dz);
        chk("len0_done_at", dat, 1);
        chk("len0_writes", ws, 0);
        chk("len0_add_cout", dc, 1'b0);
        chk("len0_zero", dz, 1'b1);
        do_op(1'b1, 0, 8'h00, 8'h00, 8'h00, 1'b0, dat, ws, dc, dz);
        chk("len0_sub_cout", dc, 1'b1);

        // start pulsed mid-RUN is ignored
        do_op(1'b0, 2, 8'h10, 8'h20, 8'h3C, 1'b1, dat, ws, dc, dz);
        chk("mid_done_at", dat, 4);
        chk("mid_d0", dmem[8'h3C], 8'h01);
        chk("mid_d1", dmem[8'h3D], 8'h00);
        chk("mid_cout", dc, 1'b1);

        // address wrap, then reset in cycle 2
        xmem[8'hFF] = 8'h12; ymem[8'h50] = 8'h34;
        @(posedge clk); #1;
        start = 1'b1; op_sub = 1'b0; len = 8'd2; x_base = 8'hFF; y_base = 8'h50; d_base = 8'h40;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("wrap_rd_en_c1", rd_en, 1'b1);
        chk("wrap_x_raddr_c1", x_raddr, 8'hFF);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("wrap_x_raddr_c2", x_raddr, 8'h00);
        chk("wrap_wdata_c2", wdata, 8'h46);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_wr_en", wr_en, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstmid_no_done", done, 1'b0);
        end
        chk("rstmid_partial_write", dmem[8'h40], 8'h46);

        // randomised traffic, including starts while busy and occasional resets
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            rst    = ($urandom_range(0, 249) == 0);
            start  = ($urandom_range(0, 3) == 0);
            op_sub = 1'($urandom_range(0, 1));
            len    = 8'($urandom_range(0, 16));
            x_base = 8'($urandom);
            y_base = ($urandom_range(0, 3) == 0) ? x_base : 8'($urandom);
            d_base = 8'($urandom);
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        repeat (25) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule
